systolic_requant_stream: RTL and testbench

//   Downstream stage of the systolic matmul top. On its done pulse, captures the
//   int32 result matrix C (ROWS x COLS, flattened) and requantizes each element
//   to int8: scale, rounding shift, zero-point, optional ReLU, saturate.

---
 rtl/systolic_requant_stream_pkg.sv | 25 ++
 rtl/systolic_requant_stream_if.sv | 20 ++
 rtl/systolic_requant_stream_requant_unit.sv | 70 +++++++
 rtl/systolic_requant_stream.sv | 141 ++++++++++++++
 tb/tb_systolic_requant_stream.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_requant_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_requant_stream_pkg
// Description : Shared types and constants for the requantizing output stream.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_requant_stream_pkg;

    localparam int ACC_W_DEFAULT  = 32;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int OUT_MAX = sat_max(DATA_W_DEFAULT);
    localparam int OUT_MIN = -sat_max(DATA_W_DEFAULT) - 1;

endpackage
`default_nettype wire

// File: rtl/systolic_requant_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_requant_stream_if
// Description : Valid/ready element stream towards the activation buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_requant_stream_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;

    modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/systolic_requant_stream_requant_unit.sv
`default_nettype none
// ============================================================================
// Module      : systolic_requant_stream_requant_unit
// Description : Two-stage int32->int8 requantizer (scale, round, zp, relu, clamp).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_requant_stream_requant_unit
    import systolic_requant_stream_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [ACC_W-1:0]  c,
    input  logic [MULT_W-1:0]        mult,
    input  logic [SHIFT_W-1:0]       shift,
    input  logic signed [DATA_W-1:0] zp,
    input  logic                     relu,
    output logic signed [DATA_W-1:0] data,
    output logic                     sat
);
    localparam int PROD_W = ACC_W + MULT_W + 1;
    // Two guard bits keep the rounding add and zero-point add free of overflow.
    localparam int SUM_W  = PROD_W + 2;
    localparam logic signed [SUM_W-1:0] c_sat_max = SUM_W'(sat_max(DATA_W));
    localparam logic signed [SUM_W-1:0] c_sat_min = SUM_W'(-sat_max(DATA_W) - 1);

    logic signed [PROD_W-1:0] w_prod, r_prod;
    logic signed [SUM_W-1:0]  w_ext, w_half, w_rnd, w_shr, w_zp, w_sum, w_relu;
    logic signed [DATA_W-1:0] w_data;
    logic                     w_sat;

    assign w_prod = PROD_W'(c) * PROD_W'($signed({1'b0, mult}));

    always_comb begin
        w_ext  = SUM_W'(r_prod);
        w_half = (shift == '0) ? '0 : (SUM_W'(1) << (shift - 1'b1));
        w_rnd  = w_ext + w_half;
        w_shr  = w_rnd >>> shift;
        w_zp   = SUM_W'(zp);
        w_sum  = w_shr + w_zp;
        w_relu = (relu && (w_sum < w_zp)) ? w_zp : w_sum;
        w_sat  = 1'b0;
        w_data = w_relu[DATA_W-1:0];
        if (w_relu > c_sat_max) begin
            w_data = c_sat_max[DATA_W-1:0];
            w_sat  = 1'b1;
        end else if (w_relu < c_sat_min) begin
            w_data = c_sat_min[DATA_W-1:0];
            w_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            data   <= '0;
            sat    <= 1'b0;
        end else if (en) begin
            r_prod <= w_prod;
            data   <= w_data;
            sat    <= w_sat;
        end
    end
endmodule
`default_nettype wire

// File: rtl/systolic_requant_stream.sv
`default_nettype none
// ============================================================================
// Module      : systolic_requant_stream
// Description : Captures the C matrix on done and streams requantized int8 elements.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_requant_stream
    import systolic_requant_stream_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         c_done,
    input  logic [ROWS*COLS*ACC_W-1:0]   c_flat,
    input  logic [MULT_W-1:0]            cfg_mult,
    input  logic [SHIFT_W-1:0]           cfg_shift,
    input  logic signed [DATA_W-1:0]     cfg_zp,
    input  logic                         cfg_relu,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  sat_count,
    output logic                         overrun,
    systolic_requant_stream_if.master    out_if
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);

    state_t r_state, w_state_nxt;
    logic signed [ACC_W-1:0]  r_buf [N];
    logic [MULT_W-1:0]        r_mult;
    logic [SHIFT_W-1:0]       r_shift;
    logic signed [DATA_W-1:0] r_zp;
    logic                     r_relu;
    logic                     r_issue, r_v1, r_v2, r_done, r_overrun;
    logic [IDX_W-1:0]         r_rd_idx, r_idx1, r_idx2;
    logic [15:0]              r_sat_count;
    logic                     w_start, w_finish, w_en, w_hs, w_sat;
    logic signed [DATA_W-1:0] w_data;

    // Whole pipeline freezes while the presented element is not accepted.
    assign w_en = !(r_v2 && !out_if.out_ready);
    assign w_hs = r_v2 && out_if.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: if (c_done) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: if (w_hs && (r_idx2 == c_last_idx)) begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_mult      <= '0;
            r_shift     <= '0;
            r_zp        <= '0;
            r_relu      <= 1'b0;
            r_issue     <= 1'b0;
            r_rd_idx    <= '0;
            r_v1        <= 1'b0;
            r_idx1      <= '0;
            r_v2        <= 1'b0;
            r_idx2      <= '0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_sat_count <= '0;
        end else begin
            r_done <= w_finish;
            if (c_done && (r_state == ST_RUN)) r_overrun <= 1'b1;
            if (w_hs && w_sat && (r_sat_count != 16'hFFFF)) r_sat_count <= r_sat_count + 16'd1;
            if (w_start) begin
                for (int i = 0; i < N; i++) r_buf[i] <= c_flat[i*ACC_W +: ACC_W];
                r_mult   <= cfg_mult;
                r_shift  <= cfg_shift;
                r_zp     <= cfg_zp;
                r_relu   <= cfg_relu;
                r_rd_idx <= '0;
                r_issue  <= 1'b1;
            end else if (w_en && r_issue) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (r_rd_idx == c_last_idx) r_issue <= 1'b0;
            end
            if (w_en) begin
                r_v1   <= r_issue;
                r_idx1 <= r_rd_idx;
                r_v2   <= r_v1;
                r_idx2 <= r_idx1;
            end
        end
    end

    systolic_requant_stream_requant_unit #(
        .ACC_W   (ACC_W),
        .DATA_W  (DATA_W),
        .MULT_W  (MULT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .c     (r_buf[r_rd_idx]),
        .mult  (r_mult),
        .shift (r_shift),
        .zp    (r_zp),
        .relu  (r_relu),
        .data  (w_data),
        .sat   (w_sat)
    );

    assign busy             = (r_state == ST_RUN);
    assign done             = r_done;
    assign overrun          = r_overrun;
    assign sat_count        = r_sat_count;
    assign out_if.out_valid = r_v2;
    assign out_if.out_data  = w_data;
    assign out_if.out_idx   = r_idx2;
    assign out_if.out_last  = r_v2 && (r_idx2 == c_last_idx);
endmodule
`default_nettype wire

// File: tb/tb_systolic_requant_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_requant_stream
// Description : Scoreboard bench for the requantizing output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_systolic_requant_stream;
    import systolic_requant_stream_pkg::*;

    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              c_done = 1'b0;
    logic [N*32-1:0]   c_flat = '0;
    logic [15:0]       cfg_mult = '0;
    logic [5:0]        cfg_shift = '0;
    logic signed [7:0] cfg_zp = '0;
    logic              cfg_relu = 1'b0;
    logic              busy, done, overrun;
    logic [15:0]       sat_count;

    systolic_requant_stream_if #(.DATA_W(8), .IDX_W(4)) sif ();

    systolic_requant_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_done    (c_done),
        .c_flat    (c_flat),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .cfg_relu  (cfg_relu),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count),
        .overrun   (overrun),
        .out_if    (sif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [12:0] sb[$];
    logic [12:0] stall_snap;
    logic        stall_prev = 1'b0;
    int job_c[N];
    int job_exp[N];

    initial begin
        #500us;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        logic [12:0] act;
        logic [12:0] exp;
        act = {sif.out_data, sif.out_idx, sif.out_last};
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!sif.out_valid || act != stall_snap) begin
                    errors++;
                    $display("FAIL stall_hold: actual valid=%0b {data,idx,last}=%h required valid=1 %h",
                             sif.out_valid, act, stall_snap);
                end
            end
            if (sif.out_valid && sif.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: actual data=%0d idx=%0d required no element",
                             $signed(sif.out_data), sif.out_idx);
                end else begin
                    exp = sb.pop_front();
                    if (act != exp) begin
                        errors++;
                        $display("FAIL stream: actual data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                                 $signed(act[12:5]), act[4:1], act[0], $signed(exp[12:5]), exp[4:1], exp[0]);
                    end
                end
            end
            stall_prev = sif.out_valid && !sif.out_ready;
            stall_snap = act;
            if (done) done_count++;
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_valid"}, sif.out_valid, 0);
        chk({name, "_data"}, sif.out_data, 0);
        chk({name, "_idx"}, sif.out_idx, 0);
        chk({name, "_last"}, sif.out_last, 0);
        chk({name, "_sat"}, sat_count, 0);
        chk({name, "_overrun"}, overrun, 0);
    endtask

    task automatic set_job(input int mult, input int shift, input int zp, input int relu, input int fill_exp);
        cfg_mult  = 16'(mult);
        cfg_shift = 6'(shift);
        cfg_zp    = 8'(zp);
        cfg_relu  = 1'(relu);
        for (int i = 0; i < N; i++) begin
            job_c[i]   = 0;
            job_exp[i] = fill_exp;
        end
    endtask

    // mode: 0 ready, 1 stall at idx 3, 2 random ready, 3 reset at idx 7, 4 c_done at idx 5
    task automatic run_job(input int mode, input string name);
        int done_before;
        int stall_cnt;
        bit fired;
        bit finished;
        for (int i = 0; i < N; i++) begin
            c_flat[i*32 +: 32] = job_c[i];
            sb.push_back({8'(job_exp[i]), 4'(i), (i == N - 1)});
        end
        sif.out_ready = 1'b1;
        done_before = done_count;
        stall_cnt = 0;
        fired = 1'b0;
        finished = 1'b0;
        @(posedge clk); #1 c_done = 1'b1;
        @(posedge clk); #1 c_done = 1'b0;
        chk({name, "_busy_t1"}, busy, 1);
        chk({name, "_valid_t1"}, sif.out_valid, 0);
        @(posedge clk); #1 chk({name, "_valid_t2"}, sif.out_valid, 0);
        @(posedge clk); #1 chk({name, "_valid_t3"}, sif.out_valid, 1);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            case (mode)
                1: begin
                    if (sif.out_valid && sif.out_idx == 4'd3 && stall_cnt < 5) begin
                        sif.out_ready = 1'b0;
                        stall_cnt++;
                    end else sif.out_ready = 1'b1;
                end
                2: sif.out_ready = 1'($urandom_range(0, 1));
                3: if (!fired && sif.out_valid && sif.out_idx == 4'd7) begin
                    rst_n = 1'b0;
                    fired = 1'b1;
                    finished = 1'b1;
                end
                4: if (!fired && sif.out_valid && sif.out_idx == 4'd5) begin
                    c_done = 1'b1;
                    c_flat = '1;
                    cfg_mult = 16'hFFFF;
                    fired = 1'b1;
                end else c_done = 1'b0;
                default: sif.out_ready = 1'b1;
            endcase
            if (!finished) begin
                @(posedge clk); #1;
                if (done) finished = 1'b1;
            end
        end
        c_done = 1'b0;
        sif.out_ready = 1'b1;
        chk({name, "_finished"}, finished, 1);
        if (mode == 3) begin
            #1 check_all_zero({name, "_rst"});
            sb.delete();
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (20) @(posedge clk);
            #1 chk({name, "_no_done"}, done_count, done_before);
            chk({name, "_idle_valid"}, sif.out_valid, 0);
        end else begin
            chk({name, "_busy_end"}, busy, 0);
            repeat (3) @(posedge clk);
            #1 chk({name, "_done_once"}, done_count, done_before + 1);
            chk({name, "_sb_empty"}, sb.size(), 0);
        end
    endtask

    initial begin
        sif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Identity ramp
        set_job(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin job_c[i] = i; job_exp[i] = i; end
        run_job(0, "ramp");
        chk("ramp_sat", sat_count, 0);

        // Saturation both ways
        set_job(1, 0, 0, 0, 0);
        job_c[0] = 1000;  job_exp[0] = OUT_MAX;
        job_c[1] = -1000; job_exp[1] = OUT_MIN;
        run_job(0, "sat");
        chk("sat_count2", sat_count, 2);

        // Rounding shift
        set_job(1, 1, 0, 0, 0);
        job_c[0] = 5;   job_exp[0] = 3;
        job_c[1] = -5;  job_exp[1] = -2;
        job_c[2] = 300; job_exp[2] = OUT_MAX;
        run_job(0, "round1");
        chk("round1_sat", sat_count, 3);
        set_job(3, 2, 0, 0, 0);
        job_c[0] = 10; job_exp[0] = 8;
        run_job(0, "round2");
        chk("round2_sat", sat_count, 3);

        // Zero point with and without relu
        set_job(1, 0, 10, 0, 10);
        job_c[0] = -3;   job_exp[0] = 7;
        job_c[1] = -200; job_exp[1] = OUT_MIN;
        job_c[2] = 50;   job_exp[2] = 60;
        run_job(0, "zp");
        chk("zp_sat", sat_count, 4);
        set_job(1, 0, 10, 1, 10);
        job_c[0] = -3;   job_exp[0] = 10;
        job_c[1] = -200; job_exp[1] = 10;
        job_c[2] = 50;   job_exp[2] = 60;
        run_job(0, "relu");
        chk("relu_sat", sat_count, 4);

        // Backpressure
        set_job(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin job_c[i] = i; job_exp[i] = i; end
        run_job(1, "stall");
        run_job(2, "random");

        // Overrun, then reset mid-job, then a clean job
        chk("overrun_pre", overrun, 0);
        set_job(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin job_c[i] = 2 * i; job_exp[i] = 2 * i; end
        run_job(4, "overrun");
        chk("overrun_set", overrun, 1);
        set_job(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin job_c[i] = i; job_exp[i] = i; end
        run_job(3, "midreset");
        run_job(0, "post_reset");
        chk("post_reset_sat", sat_count, 0);
        chk("post_reset_overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
